// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared state enum and default constants for the feedback bus arbiters
package fb_pkg;

  typedef enum logic [1:0] {
    FB_IDLE  = 2'd0,
    FB_DRIVE = 2'd1,
    FB_TURN  = 2'd2
  } fb_state_t;

  localparam int FB_N_CH     = 4;
  localparam int FB_W        = 8;
  localparam int FB_MAX_HOLD = 16;

endpackage

// File: rtl/fb_rr_pick.sv
// rtl/fb_rr_pick.sv - combinational round-robin picker: first requester at or after the pointer
module fb_rr_pick #(
  parameter int N_CH = 4,
  parameter int PW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic            o_valid,
  output logic [PW-1:0]   o_index
);

  // Scan from the farthest offset down so the nearest requester is written last and wins.
  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % N_CH]) begin
        o_valid = 1'b1;
        o_index = PW'((int'(i_ptr) + k) % N_CH);
      end
    end
  end

endmodule

// File: rtl/fb_bus_arbiter.sv
// rtl/fb_bus_arbiter.sv - round-robin owner of a shared W-bit tristate feedback bus with turnaround; FB_BUS_KEEPER_EN adds a bus keeper
module fb_bus_arbiter
  import fb_pkg::*;
#(
  parameter int N_CH     = FB_N_CH,
  parameter int W        = FB_W,
  parameter int MAX_HOLD = FB_MAX_HOLD
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         req,
  input  logic [N_CH*W-1:0]       din,
  output logic [N_CH-1:0]         grant,
  output logic [$clog2(N_CH)-1:0] owner,
  output logic                    oe_b,
  output logic [W-1:0]            bus
);

  localparam int PW = $clog2(N_CH);
  localparam int CW = $clog2(MAX_HOLD + 1);

  fb_state_t       r_state;
  logic [N_CH-1:0] r_grant;
  logic [PW-1:0]   r_owner;
  logic            r_oe_b;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_ptr;

  logic            w_pick_valid;
  logic [PW-1:0]   w_pick_idx;
  logic [W-1:0]    w_din_sel;
  logic            w_others;
  logic            w_release;
  logic [PW-1:0]   w_ptr_next;

  fb_rr_pick #(
    .N_CH (N_CH),
    .PW   (PW)
  ) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_index (w_pick_idx)
  );

  assign w_din_sel  = din[r_owner*W +: W];
  assign w_others   = |(req & ~r_grant);
  assign w_release  = !req[r_owner] || ((r_cnt >= CW'(MAX_HOLD - 1)) && w_others);
  assign w_ptr_next = (r_owner == PW'(N_CH - 1)) ? '0 : r_owner + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FB_IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_oe_b  <= 1'b1;
      r_cnt   <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        FB_IDLE, FB_TURN: begin
          if (w_pick_valid) begin
            r_state <= FB_DRIVE;
            r_grant <= {{(N_CH-1){1'b0}}, 1'b1} << w_pick_idx;
            r_owner <= w_pick_idx;
            r_oe_b  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_state <= FB_IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_oe_b  <= 1'b1;
          end
        end
        FB_DRIVE: begin
          // Releasing always passes through TURN so two drivers never overlap.
          if (w_release) begin
            r_state <= FB_TURN;
            r_ptr   <= w_ptr_next;
            r_grant <= '0;
            r_owner <= '0;
            r_oe_b  <= 1'b1;
            r_cnt   <= '0;
          end else if (r_cnt != CW'(MAX_HOLD)) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= FB_IDLE;
          r_grant <= '0;
          r_owner <= '0;
          r_oe_b  <= 1'b1;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign grant = r_grant;
  assign owner = r_owner;
  assign oe_b  = r_oe_b;

`ifdef FB_BUS_KEEPER_EN
  logic [W-1:0] r_keep;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_keep <= '0;
    end else if (r_state == FB_DRIVE) begin
      r_keep <= w_din_sel;
    end
  end

  assign bus = r_oe_b ? r_keep : w_din_sel;
`else
  assign bus = r_oe_b ? {W{1'bz}} : w_din_sel;
`endif

endmodule

// File: tb/tb_fb_bus_arbiter.sv
// tb/tb_fb_bus_arbiter.sv - directed self-checking bench for fb_bus_arbiter
module tb_fb_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic        oe_b;
  wire  [7:0]  bus;

  int n_tests = 0;
  int n_fail  = 0;

  fb_bus_arbiter #(
    .N_CH     (4),
    .W        (8),
    .MAX_HOLD (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .din   (din),
    .grant (grant),
    .owner (owner),
    .oe_b  (oe_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (rst_n) begin
      n_tests++;
      assert ($onehot0(grant) && ((grant != 4'b0) === (oe_b == 1'b0)))
      else begin
        n_fail++;
        $error("FAIL grant_onehot: grant=%b oe_b=%b required onehot0 grant consistent with oe_b", grant, oe_b);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Released bus: keeper value when built with the keeper, otherwise undriven
  // (z, or 0 where the simulator resolves undriven nets to 0).
  task automatic chk_rel(input string tag, input logic [7:0] keep_val);
`ifdef FB_BUS_KEEPER_EN
    chk(tag, {24'h0, bus}, {24'h0, keep_val});
`else
    n_tests++;
    assert ((bus === 8'hzz) || (bus === 8'h00))
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected z (keep %0h unused)", tag, bus, keep_val);
    end
`endif
  endtask

  logic [3:0] exp_g;

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    din   = 32'hC3A55A3C;

    // Reset state
    step();
    step();
    chk("rst_grant", {28'h0, grant}, 32'h0);
    chk("rst_owner", {30'h0, owner}, 32'h0);
    chk("rst_oe_b", {31'h0, oe_b}, 32'h1);
    chk_rel("rst_bus", 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_grant", {28'h0, grant}, 32'h0);
      chk("idle_oe_b", {31'h0, oe_b}, 32'h1);
    end

    // Single requester, one-cycle grant latency, long hold
    req = 4'b0100;
    step();
    chk("single_grant", {28'h0, grant}, 32'h4);
    chk("single_owner", {30'h0, owner}, 32'h2);
    chk("single_oe_b", {31'h0, oe_b}, 32'h0);
    chk("single_bus", {24'h0, bus}, 32'hA5);
    for (int i = 0; i < 40; i++) begin
      step();
      chk("single_hold", {28'h0, grant}, 32'h4);
    end
    din[23:16] = 8'h77;
    #1;
    chk("passthru_bus", {24'h0, bus}, 32'h77);
    din[23:16] = 8'hA5;

    // Asynchronous reset mid-DRIVE
    rst_n = 1'b0;
    #1;
    chk("async_rst_grant", {28'h0, grant}, 32'h0);
    chk("async_rst_oe_b", {31'h0, oe_b}, 32'h1);
    chk_rel("async_rst_bus", 8'h00);
    req = 4'b0000;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_idle", {28'h0, grant}, 32'h0);
    end

    // Release and handover: ch1 owns, ch3 waits
    req = 4'b0010;
    step();
    chk("ho_grant1", {28'h0, grant}, 32'h2);
    req = 4'b1010;
    step();
    chk("ho_keep1", {28'h0, grant}, 32'h2);
    req = 4'b1000;
    step();
    chk("ho_turn_grant", {28'h0, grant}, 32'h0);
    chk("ho_turn_oe_b", {31'h0, oe_b}, 32'h1);
    chk_rel("ho_turn_bus", 8'h5A);
    step();
    chk("ho_grant3", {28'h0, grant}, 32'h8);
    chk("ho_owner3", {30'h0, owner}, 32'h3);
    chk("ho_bus3", {24'h0, bus}, 32'hC3);
    req = 4'b0000;
    step();
    step();
    chk("ho_idle", {28'h0, grant}, 32'h0);

    // Hold preemption with MAX_HOLD=4; pointer is 0 after ch3 released
    req = 4'b0011;
    for (int i = 0; i < 11; i++) begin
      step();
      if (i < 4 || i == 10) exp_g = 4'b0001;
      else if (i == 4 || i == 9) exp_g = 4'b0000;
      else exp_g = 4'b0010;
      chk("preempt_seq", {28'h0, grant}, {28'h0, exp_g});
    end
    req = 4'b0000;
    step();
    step();

    // Round-robin fairness from a reset pointer
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req = 4'b1111;
    for (int o = 0; o < 5; o++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        chk("rr_grant", {28'h0, grant}, 32'h1 << (o % 4));
        chk("rr_owner", {30'h0, owner}, o % 4);
      end
      if (o < 4) begin
        step();
        chk("rr_turn", {28'h0, grant}, 32'h0);
      end
    end
    req = 4'b0000;
    step();
    step();

    // Keeper behaviour after ch0 drives 8'h3C and releases
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req = 4'b0001;
    step();
    chk("keep_drive_bus", {24'h0, bus}, 32'h3C);
    req = 4'b0000;
    step();
    chk("keep_turn_oe_b", {31'h0, oe_b}, 32'h1);
    chk_rel("keep_turn_bus", 8'h3C);
    step();
    chk_rel("keep_idle_bus", 8'h3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_bus_arbiter.md
# fb_bus_arbiter

Parametrised, clocked successor to the single-bit feedback tristate buffer. It lets N_CH feedback sources share one W-bit tristate feedback bus. Round-robin arbitration grants the bus to one requester at a time, and a mandatory turnaround cycle is inserted between owners so two drivers are never enabled together. It sits in the feedback path between the per-channel feedback generators and the shared feedback bus.

## Interface
- N_CH, 4, number of requesting channels (≥2)
- W, 8, bus/data width
- MAX_HOLD, 16, max consecutive DRIVE cycles while another channel waits (≥1)
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  N_CH  per-channel bus request, level
- din  input  N_CH*W  per-channel data; channel i in bits [i*W +: W]
- grant  output  N_CH  one-hot grant, registered
- owner  output  $clog2(N_CH)  index of granted channel; 0 when none
- oe_b  output  1  active-low bus drive enable (0 = driving), registered
- bus  output  W  equals din[owner] when oe_b=0; all-z when oe_b=1 (see Configuration)

## Operation
- States: IDLE, DRIVE, TURN. Reset: state IDLE, grant 0, owner 0, oe_b 1, bus z, hold counter 0, round-robin pointer 0.
- IDLE: if any req is high, pick the first requester at or after the pointer (wrapping at N_CH). Next state DRIVE with grant/owner set and oe_b=0. Otherwise stay in IDLE.
- DRIVE: the counter increments each cycle, saturating at MAX_HOLD.
  - Leave to TURN when req[owner]=0.
  - Also leave to TURN when counter ≥ MAX_HOLD-1 and any other req is high.
  - Otherwise stay. A lone owner keeps the bus indefinitely.
- On DRIVE→TURN: pointer ← owner+1 (mod N_CH), grant ← 0, oe_b ← 1, counter ← 0.
- TURN lasts exactly one cycle with nothing driven. It then arbitrates as IDLE does: go to DRIVE if any req is high, else IDLE. The former owner is lowest priority because of the pointer.
- bus is combinational from din[owner] gated by the registered oe_b. din changes during DRIVE pass straight through.
- Simultaneous requests are resolved purely by pointer order. A req that drops in the same cycle it would be granted is not granted.
- req of a non-owner never affects the current owner until the hold limit is reached.
- rst_n low at any time, including mid-DRIVE, immediately forces the reset values. This includes oe_b=1 and bus z, asynchronously.

## Timing
- Grant latency: req rises before edge k while IDLE → grant/oe_b=0 after edge k (1 cycle).
- Owner release: req[owner] falls before edge k → oe_b=1 after k, and the next owner's grant appears after edge k+1.
- Handover gap is always ≥1 full cycle with oe_b=1. There are never two grant bits high.
- Hold preemption: with a competitor waiting, the owner drives exactly MAX_HOLD cycles.
- Counter width: $clog2(MAX_HOLD+1). Pointer width: $clog2(N_CH).

## Configuration
- FB_BUS_KEEPER_EN defined: when oe_b=1 (IDLE, TURN), bus holds the last value driven rather than z. A W-bit register captures din[owner] every DRIVE cycle, and it resets to 0.
- FB_BUS_KEEPER_EN undefined: bus is all-z whenever oe_b=1. No keeper register is built.

## Structure
- A shared package fb_pkg holds the state enum (FB_IDLE, FB_DRIVE, FB_TURN) and the default constants (FB_N_CH, FB_W, FB_MAX_HOLD).
- One sub-module, fb_rr_pick, is the combinational round-robin picker: req and pointer in; valid and index out. It is reusable by other feedback arbiters.
- Output gating lives in the top module as the W-bit generalisation of the single-bit buffer. It does not instantiate the old buffer.

## Test plan
- Reset: rst_n=0 mid-DRIVE → grant=0, oe_b=1, bus=z immediately. After release, with req=0, the block stays in IDLE.
- Single requester: req=4'b0100, din[2]=8'hA5 → after 1 edge grant=4'b0100, owner=2, oe_b=0, bus=8'hA5. It holds for 40 cycles with no preemption.
- Release/handover: ch1 owns, ch3 waiting; drop req[1] → 1 cycle with oe_b=1, bus=z, then grant=4'b1000.
- Hold preemption: MAX_HOLD=4; req=4'b0011 held constant → grant sequence 0001×4, TURN, 0010×4, TURN, 0001…
- Round-robin fairness: req=4'b1111 constant → owners follow 0,1,2,3,0 with a TURN between each. There are no double grants, checked by an assertion every cycle.
- Keeper: with FB_BUS_KEEPER_EN, after ch0 drives 8'h3C and releases, bus reads 8'h3C during TURN/IDLE. Without the macro, bus reads z.
